serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched_pkg.sv | 14 +
 rtl/serial_add_sched_fa_cell.sv | 18 +
 rtl/serial_add_sched.sv | 163 ++++++++++++++++
 tb/tb_serial_add_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sched_pkg.sv
// serial_add_defs: shared definitions for the serial adder scheduler.
//   - state_t       : FSM state encoding (IDLE=00, RUN=01, DONE=10)
//   - DEFAULT_WIDTH : default operand/sum width in bits
package serial_add_defs;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_sched_fa_cell.sv
// fa_cell: single-bit full adder, purely combinational.
// Ports:
//   x, y   : operand bits
//   cin    : carry in
//   sum    : x ^ y ^ cin
//   carry  : carry out
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y ^ cin;
    assign carry = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_sched.sv
// serial_add_sched: two-requester scheduler in front of a bit-serial adder.
// One request is granted at a time (round-robin on conflict), its operands are
// added LSB-first through a single fa_cell over WIDTH cycles, and the result is
// presented until the consumer accepts it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. req_ready is combinational from req_valid and the round-robin pointer
// and is only ever high in IDLE for the one granted requester; res_valid is high
// exactly in DONE and the result fields are held until res_valid && res_ready.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   req_valid[1:0]  : per-requester request valid
//   req_ready[1:0]  : per-requester accept (one-hot or zero)
//   a0, b0, a1, b1  : requester operands
//   req_cin[1:0]    : per-requester carry in
//   res_valid       : result available
//   res_ready       : result consumer accept
//   res_sum         : sum of the granted operation
//   res_cout        : carry out of bit WIDTH-1
//   res_id          : requester that owns the result
//   busy            : FSM not in IDLE
//   dbg_state       : current FSM state encoding
//   dbg_ptr         : round-robin pointer (requester favoured on conflict)
import serial_add_defs::*;

module serial_add_sched #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       req_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic             dbg_ptr
);

    localparam int            CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_id;

    logic               w_gnt;
    logic               w_accept;
    logic               w_fa_sum;
    logic               w_fa_carry;
    logic [WIDTH-1:0]   w_sum_shift;

    fa_cell u_fa (
        .x     (r_a[0]),
        .y     (r_b[0]),
        .cin   (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB-first
    // result sits in natural bit order.
    always_comb begin
        w_sum_shift            = r_sum >> 1;
        w_sum_shift[WIDTH-1]   = w_fa_sum;
    end

    // Next-state and request-side outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready    = 2'b00;
        // Pointer only matters when both requesters compete.
        w_gnt        = (req_valid == 2'b11) ? r_ptr : req_valid[1];
        case (r_state)
            IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    req_ready[w_gnt] = 1'b1;
                    w_accept         = 1'b1;
                    w_state_next     = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_gnt ? a1 : a0;
                        r_b     <= w_gnt ? b1 : b0;
                        r_carry <= req_cin[w_gnt];
                        r_id    <= w_gnt;
                        r_cnt   <= '0;
                        r_ptr   <= ~w_gnt;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_fa_carry;
                    r_sum   <= w_sum_shift;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_cout <= w_fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign res_id    = r_id;
    assign dbg_state = r_state;
    assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: directed self-checking bench for serial_add_sched
// (WIDTH = 8). Inputs change and outputs are checked 1ns after the falling edge.
module tb_serial_add_sched;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       req_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
    logic             busy;
    logic [1:0]       dbg_state;
    logic             dbg_ptr;

    int n_assert;
    int n_fail;

    serial_add_sched #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .busy      (busy),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to the next check point: 1ns after the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Launch a request (operands already set by caller), check the grant, then
    // wait for res_valid and check latency and result. Operand inputs are
    // scrambled during RUN to show they are no longer sampled.
    task automatic do_op(input string tag, input logic [1:0] vld, input logic [1:0] exp_rdy,
                         input logic [7:0] exp_sum, input logic exp_cout, input logic exp_id,
                         input bit keep_valid);
        int edges;
        req_valid = vld;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        chk({tag, "_idle"}, 32'(dbg_state), 32'h0);
        step();
        if (!keep_valid) req_valid = 2'b00;
        a0 = WIDTH'($urandom_range(0, 255));
        b0 = WIDTH'($urandom_range(0, 255));
        a1 = WIDTH'($urandom_range(0, 255));
        b1 = WIDTH'($urandom_range(0, 255));
        req_cin = 2'($urandom_range(0, 3));
        #1;
        chk({tag, "_run"}, 32'(dbg_state), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        chk({tag, "_rdy_run"}, 32'(req_ready), 32'h0);
        edges = 0;
        while (!res_valid && edges < 40) begin
            step();
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(WIDTH));
        chk({tag, "_sum"}, 32'(res_sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(res_cout), 32'(exp_cout));
        chk({tag, "_id"}, 32'(res_id), 32'(exp_id));
    endtask

    // Complete the result handshake (res_ready already high) and check IDLE.
    task automatic finish(input string tag, input logic [7:0] exp_sum);
        step();
        chk({tag, "_back_idle"}, 32'(dbg_state), 32'h0);
        chk({tag, "_valid_low"}, 32'(res_valid), 32'h0);
        chk({tag, "_sum_hold"}, 32'(res_sum), 32'(exp_sum));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        req_cin   = 2'b00;
        res_ready = 1'b1;

        // Reset state, with requests pending to show req_ready is forced low.
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_sum", 32'(res_sum), 32'h0);
        chk("rst_cout", 32'(res_cout), 32'h0);
        chk("rst_id", 32'(res_id), 32'h0);
        chk("rst_ptr", 32'(dbg_ptr), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Requester 0 alone: 3C + 05 = 41.
        a0 = 8'h3C; b0 = 8'h05; req_cin = 2'b00;
        do_op("t1", 2'b01, 2'b01, 8'h41, 1'b0, 1'b0, 1'b0);
        finish("t1", 8'h41);
        chk("t1_ptr", 32'(dbg_ptr), 32'h1);

        // Requester 1 alone: FF + 00 + 1 wraps to 00 with carry out.
        a1 = 8'hFF; b1 = 8'h00; req_cin = 2'b10;
        do_op("t2", 2'b10, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0);
        finish("t2", 8'h00);
        chk("t2_ptr", 32'(dbg_ptr), 32'h0);

        // Both valid continuously: grants alternate 0,1,0,1.
        // req0: 12 + 34 = 46; req1: F0 + 20 + 1 = 111.
        for (int k = 0; k < 4; k++) begin
            a0 = 8'h12; b0 = 8'h34; a1 = 8'hF0; b1 = 8'h20; req_cin = 2'b10;
            if ((k % 2) == 0) begin
                do_op("t3_g0", 2'b11, 2'b01, 8'h46, 1'b0, 1'b0, 1'b1);
                finish("t3_g0", 8'h46);
            end else begin
                do_op("t3_g1", 2'b11, 2'b10, 8'h11, 1'b1, 1'b1, 1'b1);
                finish("t3_g1", 8'h11);
            end
        end
        req_valid = 2'b00;

        // Consumer stalls 5 cycles in DONE: 7F + 01 = 80.
        res_ready = 1'b0;
        a0 = 8'h7F; b0 = 8'h01; req_cin = 2'b00;
        do_op("t4", 2'b01, 2'b01, 8'h80, 1'b0, 1'b0, 1'b0);
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_stall_valid", 32'(res_valid), 32'h1);
            chk("t4_stall_sum", 32'(res_sum), 32'h80);
            chk("t4_stall_id", 32'(res_id), 32'h0);
            chk("t4_stall_ready", 32'(req_ready), 32'h0);
            chk("t4_stall_state", 32'(dbg_state), 32'h2);
        end
        res_ready = 1'b1;
        finish("t4", 8'h80);
        req_valid = 2'b00;
        chk("t4_ptr", 32'(dbg_ptr), 32'h1);

        // Reset at RUN bit 4 aborts the operation.
        a1 = 8'h0A; b1 = 8'h0B; req_cin = 2'b00;
        req_valid = 2'b10;
        #1;
        chk("t5_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("t5_run_bit4", 32'(dbg_state), 32'h1);
        rst_n = 1'b0;
        step();
        chk("t5_abort_busy", 32'(busy), 32'h0);
        chk("t5_abort_valid", 32'(res_valid), 32'h0);
        chk("t5_abort_ptr", 32'(dbg_ptr), 32'h0);
        chk("t5_abort_state", 32'(dbg_state), 32'h0);
        rst_n = 1'b1;
        #1;

        // Fresh request after abort: both valid, ptr=0 grants 0. C8 + 64 + 1 = 12D.
        a0 = 8'hC8; b0 = 8'h64; a1 = 8'h01; b1 = 8'h01; req_cin = 2'b01;
        do_op("t6", 2'b11, 2'b01, 8'h2D, 1'b1, 1'b0, 1'b0);
        finish("t6", 8'h2D);
        step();
        chk("t6_no_extra", 32'(res_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
